// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_seq_pkg;

   localparam int MULDIV_ITER = 32;

   typedef enum logic [2:0] {
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
   } muldiv_codes_t;

   typedef enum logic [1:0] {
      IDLE, CALC, DONE
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation of two values; used for operand
// magnitudes on entry and for sign correction of the result on exit.
module muldiv_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         neg_a,
   input  logic         neg_b,
   output logic [W-1:0] ya,
   output logic [W-1:0] yb
);

   assign ya = neg_a ? (~a + W'(1)) : a;
   assign yb = neg_b ? (~b + W'(1)) : b;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply or
// restoring divide on magnitudes, with sign fix-up and corner-case bypass.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ITER = MULDIV_ITER
) (
   input  logic            clk,
   input  logic            nReset,
   input  logic            start,
   input  muldiv_codes_t   op,
   input  logic [XLEN-1:0] rs1F,
   input  logic [XLEN-1:0] rs2F,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   muldiv_state_t     state, state_next;
   muldiv_codes_t     op_q;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc, acc_step;
   logic [XLEN-1:0]   opb;
   logic              neg_q;

   logic              accept, signed1, signed2, s1, s2;
   logic              div_zero, ovf, special;
   logic [XLEN-1:0]   special_val, mag1, mag2, final_val, div_val;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN:0]   shl;
   logic [XLEN+1:0]   trial;
   logic [2*XLEN-1:0] fix_prod, fix_div;
   logic              unused_bits;

   assign accept  = (state == IDLE) && start && !flush;
   assign signed1 = op inside {MUL, MULH, MULHSU, DIV, REM};
   assign signed2 = op inside {MUL, MULH, DIV, REM};
   assign s1      = signed1 && rs1F[XLEN-1];
   assign s2      = signed2 && rs2F[XLEN-1];

   assign div_zero = (op inside {DIV, DIVU, REM, REMU}) && (rs2F == '0);
   assign ovf      = (op inside {DIV, REM}) && (rs1F == {1'b1, {(XLEN-1){1'b0}}})
                     && (rs2F == '1);
   assign special  = div_zero || ovf;

   always_comb begin
      special_val = '0;
      if (div_zero)
         special_val = (op inside {DIV, DIVU}) ? '1 : rs1F;
      else if (op == DIV)
         special_val = rs1F;
   end

   muldiv_signfix #(.W(XLEN)) u_fix_in (
      .a(rs1F), .b(rs2F), .neg_a(s1), .neg_b(s2), .ya(mag1), .yb(mag2)
   );

   // One iteration: low accumulator half holds the multiplier or dividend bits
   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      shl     = {acc, 1'b0};
      trial   = {1'b0, shl[2*XLEN:XLEN]} - {2'b00, opb};
      if (op_q inside {MUL, MULH, MULHSU, MULHU})
         acc_step = {mul_sum, acc[XLEN-1:1]};
      else if (!trial[XLEN+1])
         acc_step = {trial[XLEN-1:0], shl[XLEN-1:1], 1'b1};
      else
         acc_step = shl[2*XLEN-1:0];
   end

   assign div_val = (op_q inside {DIV, DIVU}) ? acc_step[XLEN-1:0]
                                              : acc_step[2*XLEN-1:XLEN];

   muldiv_signfix #(.W(2*XLEN)) u_fix_out (
      .a(acc_step), .b({{XLEN{1'b0}}, div_val}), .neg_a(neg_q), .neg_b(neg_q),
      .ya(fix_prod), .yb(fix_div)
   );

   assign unused_bits = ^{fix_div[2*XLEN-1:XLEN], trial[XLEN]};

   always_comb begin
      case (op_q)
         MUL:                  final_val = fix_prod[XLEN-1:0];
         MULH, MULHSU, MULHU:  final_val = fix_prod[2*XLEN-1:XLEN];
         default:              final_val = fix_div[XLEN-1:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nReset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
         done  <= (state_next == DONE);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = special ? DONE : CALC;
         CALC:    if (cnt == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   always_comb begin
      stall = nReset && (accept || (state == CALC));
   end

   // Datapath: operand capture, iteration and result load
   always_ff @(posedge clk) begin
      if (!nReset) begin
         cnt    <= '0;
         acc    <= '0;
         result <= '0;
      end else if (accept) begin
         op_q  <= op;
         opb   <= mag2;
         neg_q <= (op == REM) ? s1 : (s1 ^ s2);
         acc   <= {{XLEN{1'b0}}, mag1};
         cnt   <= '0;
         if (special) result <= special_val;
      end else if ((state == CALC) && !flush) begin
         acc <= acc_step;
         if (cnt == LAST) begin
            cnt    <= '0;
            result <= final_val;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, latency, corner cases,
// flush, mid-operation reset and back-to-back issue.
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   logic          clk = 1'b0;
   logic          nReset;
   logic          start;
   muldiv_codes_t op;
   logic [31:0]   rs1F, rs2F;
   logic          flush;
   logic          stall, busy, done;
   logic [31:0]   result;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [31:0] last_exp;

   muldiv_seq #(.XLEN(32), .ITER(32)) dut (
      .clk(clk), .nReset(nReset), .start(start), .op(op), .rs1F(rs1F),
      .rs2F(rs2F), .flush(flush), .stall(stall), .busy(busy), .done(done),
      .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   // Issues one op in the current cycle (cycle 0) and follows it to done.
   task automatic run_op(input string tag, input muldiv_codes_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, output int t_start, output int t_done);
      logic ctl_ok;
      op = o; rs1F = a; rs2F = b; start = 1'b1;
      t_start = cyc;
      #1;
      chk({tag, " stall@0"}, stall, 1);
      @(posedge clk); #1;
      start = 1'b0;
      ctl_ok = 1'b1;
      while (!done && (cyc - t_start) < 100) begin
         if (stall !== 1'b1 || busy !== 1'b1) ctl_ok = 1'b0;
         @(posedge clk); #1;
      end
      t_done = cyc;
      chk({tag, " latency"}, t_done - t_start, exp_lat);
      chk({tag, " result"}, result, exp_res);
      chk({tag, " stall/busy while working"}, ctl_ok, 1);
      chk({tag, " stall@done"}, stall, 0);
      last_exp = exp_res;
      @(posedge clk); #1;
      chk({tag, " done one cycle"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int ts, td, ts2, td2;
      nReset = 1'b0; start = 1'b1; flush = 1'b0;
      op = MUL; rs1F = 32'd3; rs2F = 32'd3;
      repeat (3) @(posedge clk);
      #1;
      chk("reset stall", stall, 0);
      chk("reset outputs", {busy, done, result}, 34'd0);
      start = 1'b0; nReset = 1'b1;
      @(posedge clk); #1;

      run_op("MUL 7*6", MUL, 32'd7, 32'd6, 32'd42, 33, ts, td);
      run_op("MULH -1*-1", MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, ts, td);
      run_op("MULHU", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, ts, td);
      run_op("MULHSU", MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, ts, td);
      run_op("MULH min*min", MULH, 32'h80000000, 32'h80000000, 32'h40000000, 33, ts, td);
      run_op("MUL min*-1", MUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, ts, td);
      run_op("DIV -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, ts, td);
      run_op("REM -7/2", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, ts, td);
      run_op("DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd14, 33, ts, td);
      run_op("REMU 100/7", REMU, 32'd100, 32'd7, 32'd2, 33, ts, td);
      run_op("DIVU max/1", DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, ts, td);
      run_op("DIV 5/0", DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, ts, td);
      run_op("REM 5/0", REM, 32'd5, 32'd0, 32'd5, 1, ts, td);
      run_op("DIV ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, ts, td);
      run_op("REM ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, ts, td);

      // flush at cycle 10 of a DIVU
      op = DIVU; rs1F = 32'd1000; rs2F = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush ctl", {stall, busy, done}, 3'b000);
      chk("flush result kept", result, last_exp);
      run_op("after flush DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd14, 33, ts, td);

      // flush beats start in IDLE
      op = MUL; rs1F = 32'd2; rs2F = 32'd2; start = 1'b1; flush = 1'b1;
      #1;
      chk("flush vs start stall", stall, 0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush vs start busy", busy, 0);

      // reset in cycle 5 of a MUL
      op = MUL; rs1F = 32'd9; rs2F = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      nReset = 1'b0;
      #1;
      chk("mid reset stall", stall, 0);
      @(posedge clk); #1;
      chk("mid reset outputs", {stall, busy, done, result}, 35'd0);
      nReset = 1'b1;
      @(posedge clk); #1;

      // back-to-back MUL then DIV
      run_op("b2b MUL 3*4", MUL, 32'd3, 32'd4, 32'd12, 33, ts, td);
      run_op("b2b DIV 20/-4", DIV, 32'd20, 32'hFFFFFFFC, 32'hFFFFFFFB, 33, ts2, td2);
      chk("b2b second start", ts2 - ts, 34);
      chk("b2b second done", td2 - ts, 67);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
